// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the multi-cycle multiply/divide unit in E; owns HI/LO.
// Latency: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES, HI/LO visible the cycle after Busy falls; mthi/mtlo next cycle.
// Backpressure: Stall holds MDU-class instructions in D while Busy or while a mult/div is starting in E.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   Start, MduOp - E-stage MDU write qualifier and opcode (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   A, B         - forwarded rs / rt operands
//   MdReq_D      - D-stage instruction is MDU-class
//   Busy, Stall  - in-flight indicator (from state flop) and combinational D-stage stall
//   HI, LO       - architectural HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MduOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MdReq_D,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;

  // Ops that occupy the unit for a multi-cycle Busy period.
  logic is_long_op;
  assign is_long_op = (MduOp >= OP_MULT) && (MduOp <= OP_DIVU);

  // ---------------- datapath: products and quotients ----------------
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign a_zx   = {32'd0, A};
  assign b_zx   = {32'd0, B};
  assign prod_s = a_sx * b_sx;   // low 64 bits of the sign-extended product are the signed product
  assign prod_u = a_zx * b_zx;

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case:
  // |A| = 0x80000000, |B| = 1, signs equal -> quotient 0x80000000, remainder 0.
  logic        b_zero;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] uq_mag, ur_mag, q_s, r_s, q_u, r_u;
  assign b_zero     = (B == 32'd0);
  assign a_mag      = A[31] ? (32'd0 - A) : A;
  assign b_mag      = B[31] ? (32'd0 - B) : B;
  // Divide-by-zero results are discarded; the safe divisor only keeps the arithmetic defined.
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_safe     = b_zero ? 32'd1 : B;
  assign uq_mag     = a_mag / b_mag_safe;
  assign ur_mag     = a_mag % b_mag_safe;
  assign q_s        = (A[31] ^ B[31]) ? (32'd0 - uq_mag) : uq_mag;
  assign r_s        = A[31] ? (32'd0 - ur_mag) : ur_mag;   // remainder follows the dividend
  assign q_u        = A / b_safe;
  assign r_u        = A % b_safe;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start && is_long_op) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(1))     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- counter / HI-LO / pending update ----------------
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MduOp)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              cnt_d     = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              cnt_d     = CW'(MULT_CYCLES);
            end
            OP_DIV: begin
              // Divide by zero re-commits the current HI/LO after the full Busy period.
              pend_hi_d = b_zero ? hi_q : r_s;
              pend_lo_d = b_zero ? lo_q : q_s;
              cnt_d     = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
              pend_hi_d = b_zero ? hi_q : r_u;
              pend_lo_d = b_zero ? lo_q : q_u;
              cnt_d     = CW'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Start is ignored here; both words commit together on the last Busy cycle.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    Busy  = (state_q == S_RUN);
    Stall = MdReq_D && ((state_q == S_RUN) || (Start && is_long_op));
    HI    = hi_q;
    LO    = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start, md_req;
  logic [2:0]  MduOp;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  int passed = 0;
  int total  = 0;

  // Reference model state: architectural HI/LO, pending result, busy cycles left.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MduOp   (MduOp),
    .A       (A),
    .B       (B),
    .MdReq_D (md_req),
    .Busy    (Busy),
    .Stall   (Stall),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Architectural effect of one clock edge, from the operation rules.
  task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] ua, ub, pu;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
        3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_left = MC; end
        3'd2: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; m_left = MC; end
        3'd3: begin
          if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
          else begin q = sa / sb; r = sa % sb; m_phi = r[31:0]; m_plo = q[31:0]; end
          m_left = DC;
        end
        3'd4: begin
          if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
          else begin m_phi = a % b; m_plo = a / b; end
          m_left = DC;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One cycle: drive, check outputs against the model, clock, advance model.
  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic md);
    logic exp_busy, exp_stall;
    reset = rst; Start = st; MduOp = op; A = a; B = b; md_req = md;
    #1;
    exp_busy  = (m_left > 0);
    exp_stall = md && (exp_busy || (st && op >= 3'd1 && op <= 3'd4));
    chk("busy",  {31'd0, Busy},  {31'd0, exp_busy});
    chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    @(posedge clk);
    model_edge(rst, st, op, a, b);
    #1;
  endtask

  task automatic idle(input int n, input logic md);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, md);
  endtask

  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; Start = 1'b0; MduOp = 3'd0; A = '0; B = '0; md_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;

    // Reset state, Stall low with an MDU instruction in D.
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_hi", HI, 32'h0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);

    // Signed multiply -2 * 3, Stall held with MdReq_D.
    step(1'b0, 1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    idle(MC, 1'b1);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    chk("mult_busy_end", {31'd0, Busy}, 32'd0);
    chk("mult_stall_end", {31'd0, Stall}, 32'd0);

    // Unsigned multiply, unrelated D instruction: no Stall while Busy.
    step(1'b0, 1'b1, 3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    idle(MC, 1'b0);
    chk("multu_hi", HI, 32'h2);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    // Signed and unsigned divide.
    step(1'b0, 1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    idle(DC, 1'b1);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2, 1'b0);
    idle(DC, 1'b0);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // Overflow case.
    step(1'b0, 1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(DC, 1'b0);
    chk("divov_lo", LO, 32'h80000000);
    chk("divov_hi", HI, 32'h0);

    // Divide by zero keeps HI/LO, full Busy period.
    step(1'b0, 1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'd6, 32'h22, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 32'd99, 32'd0, 1'b0);
    idle(DC - 1, 1'b0);
    chk("div0_busy_last", {31'd0, Busy}, 32'd1);
    idle(1, 1'b0);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    // mthi is immediate and not Busy.
    step(1'b0, 1'b1, 3'd5, 32'h1234, 32'd0, 1'b1);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);

    // Back-to-back: ignored Start at T+3, accepted at T+6.
    step(1'b0, 1'b1, 3'd1, 32'd5, 32'd6, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 3'd2, 32'd100, 32'd100, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 3'd1, 32'd7, 32'd8, 1'b1);
    chk("b2b_first_lo", LO, 32'd30);
    idle(MC, 1'b1);
    chk("b2b_second_lo", LO, 32'd56);

    // Reset mid-divide: result discarded, no late update.
    step(1'b0, 1'b1, 3'd3, 32'd1000, 32'd7, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("rstmid_busy", {31'd0, Busy}, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    idle(8, 1'b0);
    chk("rstmid_late_lo", LO, 32'd0);

    // Randomized traffic including corner operands and occasional reset.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(1, 9);
        3: rb = -$urandom_range(1, 9);
        default: ;
      endcase
      step($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the multi-cycle multiply/divide unit in the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from E with forwarded operands, and runs multiplies and divides for a fixed cycle count. It owns the HI/LO registers and raises a stall toward the D-stage pipeline registers. While the unit is busy, or an operation is just starting, no MDU-class instruction may leave D.

## Interface
- MULT_CYCLES, 5, Busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, Busy duration of div/divu in cycles (≥1)
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- Start  in  1  E-stage instruction is an MDU write op; single-cycle qualifier
- MduOp  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others are treated as none
- A  in  32  forwarded rs value in E
- B  in  32  forwarded rt value in E
- MdReq$D  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy  out  1  registered; high while a mult/div is in flight
- Stall  out  1  combinational; MdReq$D && (Busy || (Start && MduOp in {001..100}))
- HI  out  32  HI register (remainder / high product word)
- LO  out  32  LO register (quotient / low product word)

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1. A down-counter cnt holds the remaining cycles, width sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE + Start + mult/multu:
  - Compute the 64-bit product of A and B, signed for mult and unsigned for multu.
  - Latch {hi,lo} into pending registers. cnt←MULT_CYCLES; go to RUN.
- IDLE + Start + div/divu:
  - Signed div truncates toward zero; the remainder takes the sign of A. divu is unsigned.
  - Pending lo←quotient, hi←remainder. cnt←DIV_CYCLES; go to RUN.
  - B==0: pending←current HI/LO, so HI/LO are unchanged; the Busy period still elapses.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- IDLE + Start + mthi: HI←A at this edge; no Busy; LO unchanged. mtlo: LO←A likewise.
- IDLE + Start + none/reserved MduOp: no effect.
- RUN: cnt←cnt−1 each cycle. When cnt==1, HI/LO←pending and the next state is IDLE.
- Start while in RUN is ignored, with no state change. The Stall contract prevents it in legal operation.
- mfhi/mflo read HI/LO directly in E. Stall guarantees they never reach E while Busy.
- HI/LO are never visible in a partially updated state: both words update on the same edge.

## Timing
- Reset: state IDLE, cnt=0, Busy=0, HI=0, LO=0, pending=0. Reset applies at the next rising edge and overrides Start and any in-flight RUN; the aborted result is discarded.
- Start sampled in cycle T for mult/div with N cycles (N = MULT_CYCLES or DIV_CYCLES):
  - Busy is high in cycles T+1 … T+N.
  - HI/LO take the new value at the edge ending T+N and are visible in T+N+1 with Busy=0.
- mthi/mtlo at T: the new value is visible at T+1.
- Stall:
  - In cycle T with an MDU instr in D, Stall=1 due to the Start term.
  - It remains 1 through T+N.
  - It first drops in T+N+1, so a following mfhi enters E at T+N+2 and reads the final HI.
- Back-to-back: a new Start is accepted in cycle T+N+1, the first IDLE cycle.
- Stall never depends on non-MDU instructions; an unrelated D instruction proceeds while Busy.

## Test plan
- Reset to idle:
  - Stimulus: reset=1 for 2 cycles, then 0.
  - Required: HI=LO=0, Busy=0, Stall=0 even with MdReq$D=1.
- Signed multiply with defaults:
  - Stimulus: mult A=0xFFFFFFFE(−2), B=3 at T.
  - Required: Busy=1 in T+1…T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
  - multu with the same operands → HI=0x2, LO=0xFFFFFFFA.
- Signed divide:
  - div A=−7, B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div B=0 after HI=0x11, LO=0x22 → HI/LO remain 0x11/0x22; Busy lasts 10 cycles.
- Stall interaction:
  - Stimulus: mult at T with MdReq$D=1 held.
  - Required: Stall=1 in T…T+5, 0 at T+6. With MdReq$D=0, Stall=0 throughout while Busy=1.
- mthi/mtlo and back-to-back:
  - mthi A=0x1234 at T → HI=0x1234 at T+1, no Busy.
  - mult issued at T+6 after an earlier mult at T is accepted; a Start at T+3 is ignored.
- Reset mid-operation:
  - Stimulus: div started at T, reset at T+4.
  - Required: Busy=0, HI=LO=0 at T+5, and no late update at T+11.
